// File: rtl/stack_port_arbiter_pkg.sv
// Shared types and constants for the two-port stack arbiter.
// Optional feature macro used by this slice: STACK_ARB_ERR_EN (full/empty rejection and err).
package stack_arb_pkg;

    localparam int DATA_W = 4;
    localparam int NPORT  = 2;

    localparam logic OP_PUSH = 1'b1;
    localparam logic OP_POP  = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/stack_port_arbiter_if.sv
// Port-side handshake and stack-side bus of the arbiter, bundled for connection.
// slave = arbiter view, master = requester/stack environment view.
interface stack_port_arbiter_if;
    import stack_arb_pkg::*;

    logic              req0;
    logic              req1;
    logic              op0;
    logic              op1;
    logic [DATA_W-1:0] din0;
    logic [DATA_W-1:0] din1;
    logic              ack0;
    logic              ack1;
    logic [DATA_W-1:0] rdata;
    logic              err;

    logic              stk_enable;
    logic              stk_push_pop;
    logic [DATA_W-1:0] stk_data_in;
    logic              stk_full;
    logic              stk_empty;
    logic [DATA_W-1:0] stk_data_out;

    modport slave (
        input  req0, req1, op0, op1, din0, din1,
        input  stk_full, stk_empty, stk_data_out,
        output ack0, ack1, rdata, err,
        output stk_enable, stk_push_pop, stk_data_in
    );

    modport master (
        output req0, req1, op0, op1, din0, din1,
        output stk_full, stk_empty, stk_data_out,
        input  ack0, ack1, rdata, err,
        input  stk_enable, stk_push_pop, stk_data_in
    );

endinterface

// File: rtl/stack_port_arbiter_rr_arb2.sv
// Two-way round-robin selector; the pointer remembers the last winner and
// moves only when update is pulsed with a non-empty grant.
module rr_arb2
    import stack_arb_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [NPORT-1:0] req,
    input  logic             update,
    output logic [NPORT-1:0] grant
);

    logic last_q;
    logic last_d;

    always_comb begin
        grant = req;
        // Contention: the port that did not win last time goes first.
        if (req == 2'b11) begin
            grant = last_q ? 2'b01 : 2'b10;
        end
        last_d = last_q;
        if (update && (grant != '0)) begin
            last_d = grant[1];
        end
    end

    // Pointer resets to port1 so that port0 is favoured first.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/stack_port_arbiter.sv
// Arbitrates two requesters onto one stack port: IDLE -> ISSUE -> RESP.
// Define STACK_ARB_ERR_EN to reject push-on-full / pop-on-empty and report err.
module stack_port_arbiter
    import stack_arb_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    stack_port_arbiter_if.slave  bus
);

    arb_state_e        state_q, state_d;
    logic [NPORT-1:0]  win_q, win_d;
    logic              op_q, op_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic              err_q, err_d;

    logic [NPORT-1:0]  arb_req;
    logic [NPORT-1:0]  grant;
    logic              arb_update;
    logic              reject;
    logic              in_issue;

    // In RESP the arbiter sees only the latched winner, so a late request
    // from the other port cannot redirect the pointer update.
    assign arb_req    = (state_q == ST_RESP) ? win_q : {bus.req1, bus.req0};
    assign arb_update = (state_q == ST_RESP);
    assign in_issue   = (state_q == ST_ISSUE);

    rr_arb2 u_rr_arb2 (
        .clk    (clk),
        .reset  (reset),
        .req    (arb_req),
        .update (arb_update),
        .grant  (grant)
    );

`ifdef STACK_ARB_ERR_EN
    assign reject = (op_q == OP_PUSH) ? bus.stk_full : bus.stk_empty;
`else
    logic unused_status;
    assign unused_status = bus.stk_full ^ bus.stk_empty;
    assign reject        = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        op_d    = op_q;
        din_d   = din_q;
        rdata_d = rdata_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant != '0) begin
                    win_d   = grant;
                    op_d    = grant[0] ? bus.op0  : bus.op1;
                    din_d   = grant[0] ? bus.din0 : bus.din1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Pop returns the pre-pop top; the stack updates on this same edge.
                if (reject) begin
                    rdata_d = '0;
                end else if (op_q == OP_PUSH) begin
                    rdata_d = din_q;
                end else begin
                    rdata_d = bus.stk_data_out;
                end
                ack0_d  = win_q[0];
                ack1_d  = win_q[1];
                err_d   = reject;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            win_q   <= '0;
            op_q    <= OP_POP;
            din_q   <= '0;
            rdata_q <= '0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            op_q    <= op_d;
            din_q   <= din_d;
            rdata_q <= rdata_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            err_q   <= err_d;
        end
    end

    // Stack strobe decodes the registered state, so an async reset drops it at once.
    assign bus.stk_enable   = in_issue && !reject;
    assign bus.stk_push_pop = in_issue && op_q;
    assign bus.stk_data_in  = in_issue ? din_q : '0;
    assign bus.ack0         = ack0_q;
    assign bus.ack1         = ack1_q;
    assign bus.rdata        = rdata_q;
    assign bus.err          = err_q;

endmodule

// File: tb/tb_stack_port_arbiter.sv
// Directed + randomized bench for stack_port_arbiter against a transaction-level
// model (round-robin rule plus a reference stack); honours STACK_ARB_ERR_EN.
module tb_stack_port_arbiter;
    import stack_arb_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    stack_port_arbiter_if bus();

    stack_port_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural stack attached to the arbiter's stack port.
    logic [3:0] env_mem [DEPTH];
    int         env_cnt = 0;
    logic       env_clear;

    always @(posedge clk) begin
        if (env_clear) begin
            env_cnt <= 0;
        end else if (bus.stk_enable) begin
            if (bus.stk_push_pop) begin
                if (env_cnt < DEPTH) begin
                    env_mem[env_cnt] <= bus.stk_data_in;
                    env_cnt <= env_cnt + 1;
                end
            end else if (env_cnt > 0) begin
                env_cnt <= env_cnt - 1;
            end
        end
    end

    assign bus.stk_full     = (env_cnt == DEPTH);
    assign bus.stk_empty    = (env_cnt == 0);
    assign bus.stk_data_out = (env_cnt > 0) ? env_mem[env_cnt-1] : 4'h0;

    int vectors = 0;
    int miscompares = 0;

    logic [3:0] ref_stk[$];
    logic       ref_last;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at #1 after an edge that leaves the DUT in IDLE; returns one edge
    // after the ack cycle, again in IDLE.
    task automatic txn(input logic r0, input logic r1, input logic o0, input logic o1,
                       input logic [3:0] d0, input logic [3:0] d1,
                       input string tag, output logic got_port);
        logic       w;
        logic       op;
        logic [3:0] din;
        logic       rej;
        logic [3:0] exp_rd;
        w   = (r0 && r1) ? ~ref_last : r1;
        op  = w ? o1 : o0;
        din = w ? d1 : d0;
        rej = 1'b0;
`ifdef STACK_ARB_ERR_EN
        rej = op ? (ref_stk.size() == DEPTH) : (ref_stk.size() == 0);
`endif
        if (rej) exp_rd = 4'h0;
        else if (op) exp_rd = din;
        else exp_rd = (ref_stk.size() > 0) ? ref_stk[$] : 4'h0;

        bus.req0 = r0; bus.req1 = r1;
        bus.op0  = o0; bus.op1  = o1;
        bus.din0 = d0; bus.din1 = d1;

        @(posedge clk); #1;
        chk({tag, "_en"}, bus.stk_enable, !rej);
        if (!rej) begin
            chk({tag, "_pp"}, bus.stk_push_pop, op);
            chk({tag, "_sdi"}, bus.stk_data_in, din);
        end
        chk({tag, "_noack_issue"}, {bus.ack1, bus.ack0}, 2'b00);

        @(posedge clk); #1;
        got_port = bus.ack1;
        chk({tag, "_ack0"}, bus.ack0, !w);
        chk({tag, "_ack1"}, bus.ack1, w);
        chk({tag, "_rdata"}, bus.rdata, exp_rd);
        chk({tag, "_err"}, bus.err, rej);
        chk({tag, "_en_resp"}, bus.stk_enable, 1'b0);

        if (!rej) begin
            if (op) begin
                if (ref_stk.size() < DEPTH) ref_stk.push_back(din);
            end else if (ref_stk.size() > 0) begin
                void'(ref_stk.pop_back());
            end
        end
        ref_last = w;

        @(posedge clk); #1;
        chk({tag, "_ack_done"}, {bus.ack1, bus.ack0}, 2'b00);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
    endtask

    initial begin
        logic p;
        logic [1:0] r;
        reset = 1'b0;
        env_clear = 1'b1;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.op0  = 1'b0; bus.op1  = 1'b0;
        bus.din0 = 4'h0; bus.din1 = 4'h0;
        ref_last = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", {bus.ack1, bus.ack0}, 2'b00);
        chk("rst_err", bus.err, 1'b0);
        chk("rst_en", bus.stk_enable, 1'b0);
        chk("rst_rdata", bus.rdata, 4'h0);
        chk("rst_pp", bus.stk_push_pop, 1'b0);
        chk("rst_sdi", bus.stk_data_in, 4'h0);

        @(negedge clk);
        reset = 1'b1;
        env_clear = 1'b0;
        @(posedge clk); #1;
        repeat (2) begin
            @(posedge clk); #1;
            chk("idle_en", bus.stk_enable, 1'b0);
            chk("idle_ack", {bus.ack1, bus.ack0}, 2'b00);
        end

        txn(1'b1, 1'b0, 1'b1, 1'b0, 4'hA, 4'h0, "push0", p);
        txn(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, "pop1", p);
        chk("pop1_empty", bus.stk_empty, 1'b1);

        for (int i = 0; i < 4; i++) begin
            txn(1'b1, 1'b1, 1'b1, 1'b1, 4'(i + 1), 4'(i + 8), "cont", p);
            chk("cont_order", p, i[0]);
        end

        txn(1'b1, 1'b0, 1'b1, 1'b0, 4'h5, 4'h0, "ovf", p);
        for (int i = 0; i < 4; i++) begin
            txn(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, "drain", p);
        end
        txn(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, "udf", p);

        // Reset while the push is being issued.
        bus.req0 = 1'b1; bus.op0 = 1'b1; bus.din0 = 4'h7;
        @(posedge clk); #1;
        chk("rstmid_en_before", bus.stk_enable, 1'b1);
        reset = 1'b0;
        #1;
        chk("rstmid_en", bus.stk_enable, 1'b0);
        repeat (3) begin
            @(posedge clk); #1;
            chk("rstmid_ack", {bus.ack1, bus.ack0}, 2'b00);
            chk("rstmid_en_low", bus.stk_enable, 1'b0);
        end
        @(negedge clk);
        reset = 1'b1;
        bus.req0 = 1'b0;
        ref_last = 1'b1;
        @(posedge clk); #1;
        chk("rstmid_idle", {bus.ack1, bus.ack0, bus.stk_enable}, 3'b000);
        txn(1'b1, 1'b1, 1'b1, 1'b1, 4'h3, 4'hC, "post_rst", p);
        chk("post_rst_port", p, 1'b0);

        repeat (40) begin
            r = 2'($urandom_range(1, 3));
            txn(r[0], r[1], 1'($urandom), 1'($urandom),
                4'($urandom), 4'($urandom), "rand", p);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
